// File: rtl/filt_sel_buf_if.sv
// Valid/ready data-transfer interface used on both sides of filt_sel_buf.
//   valid  producer -> consumer   data word is present
//   ready  consumer -> producer   consumer accepts the word this cycle
//   data   producer -> consumer   payload, W bits
// master drives valid/data, slave drives ready.
interface filt_sel_buf_if #(
   parameter int W = 1
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/filt_sel_buf.sv
// filt_sel_buf: stream filter that keeps items whose ctrl code is enabled in
// SEL_MASK, strips ctrl, folds the eot of a dropped end-of-transaction item
// into the last kept item, and decouples the output through a DEPTH-entry FIFO.
// Ports:
//   clk       clock
//   rst       asynchronous, active-low reset
//   din       slave side,  data = {eot[LVL-1:0], ctrl[W_CTRL-1:0], data[W_DIN-1:0]}
//   dout      master side, data = {eot[LVL-1:0], data[W_DIN-1:0]}
//   drop_cnt  saturating count of inner transactions that produced no kept item
module filt_sel_buf #(
   parameter int                    W_DIN    = 16,
   parameter int                    LVL      = 1,
   parameter int                    W_CTRL   = 1,
   parameter logic [2**W_CTRL-1:0]  SEL_MASK = 2'b01,
   parameter int                    DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst,
   filt_sel_buf_if.slave     din,
   filt_sel_buf_if.master    dout,
   output logic [15:0]       drop_cnt
);
   localparam int W_OUT = LVL + W_DIN;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic [W_DIN-1:0]  in_data;
   logic [W_CTRL-1:0] in_ctrl;
   logic [LVL-1:0]    in_eot;

   logic              pend_v_q, pend_v_d;
   logic              pend_done_q, pend_done_d;
   logic [W_OUT-1:0]  pend_q, pend_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [W_OUT-1:0]  mem_q [DEPTH];
   logic [W_OUT-1:0]  mem_d [DEPTH];

   logic sel, deot, dmid, full, empty, push, pop, sel_acc;

   assign in_data = din.data[W_DIN-1:0];
   assign in_ctrl = din.data[W_DIN +: W_CTRL];
   assign in_eot  = din.data[W_DIN + W_CTRL +: LVL];

   assign dout.valid = !empty;
   assign dout.data  = mem_q[rd_ptr_q];
   assign drop_cnt   = drop_cnt_q;

   // Classification, handshake and next-state logic. The pending register
   // holds the newest kept item until its final eot is known: it is pushed
   // when it is already done, or when a later kept item displaces it. A push
   // into a full FIFO is legal only together with a pop in the same cycle.
   always_comb begin
      pend_v_d    = pend_v_q;
      pend_done_d = pend_done_q;
      pend_d      = pend_q;
      drop_cnt_d  = drop_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mem_d       = mem_q;

      sel   = din.valid &&  SEL_MASK[in_ctrl];
      deot  = din.valid && !SEL_MASK[in_ctrl] &&  in_eot[0];
      dmid  = din.valid && !SEL_MASK[in_ctrl] && !in_eot[0];
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      pop   = !empty && dout.ready;
      push  = pend_v_q && (!full || pop) && (pend_done_q || sel);
      sel_acc   = sel && (!pend_v_q || push);
      din.ready = sel_acc || deot || dmid;

      if (push) begin
         mem_d[wr_ptr_q] = pend_q;
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         pend_v_d = 1'b0;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (sel_acc) begin
         pend_d      = {in_eot, in_data};
         pend_v_d    = 1'b1;
         pend_done_d = in_eot[0];
      end

      // A dropped eot closes the current transaction. If that transaction
      // has an open kept item, the eot is folded into it; otherwise the
      // transaction produced nothing (a done pending item belongs to the
      // previous transaction) and is counted.
      if (deot) begin
         if (pend_v_q && !pend_done_q) begin
            pend_d[W_OUT-1 -: LVL] = in_eot;
            pend_done_d = 1'b1;
         end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end
   end

   // Control state with asynchronous reset; reset discards pending and
   // queued items.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_v_q    <= 1'b0;
         pend_done_q <= 1'b0;
         pend_q      <= '0;
         drop_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         pend_v_q    <= pend_v_d;
         pend_done_q <= pend_done_d;
         pend_q      <= pend_d;
         drop_cnt_q  <= drop_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_filt_sel_buf.sv
// Self-checking bench for filt_sel_buf (W_CTRL=2, SEL_MASK=4'b1010, LVL=2,
// DEPTH=3). A transaction-level model predicts the kept output stream and the
// drop count; directed sequences pin the model with literal expectations, then
// random traffic with random output backpressure is checked cycle by cycle.
module tb_filt_sel_buf;
   localparam int W_DIN  = 16;
   localparam int LVL    = 2;
   localparam int W_CTRL = 2;
   localparam int DEPTH  = 3;
   localparam logic [3:0] SEL_MASK = 4'b1010;
   localparam int W_IN  = LVL + W_CTRL + W_DIN;
   localparam int W_OUT = LVL + W_DIN;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] drop_cnt;
   int errors = 0;
   int checks = 0;

   filt_sel_buf_if #(.W(W_IN))  din_if ();
   filt_sel_buf_if #(.W(W_OUT)) dout_if ();

   filt_sel_buf #(
      .W_DIN(W_DIN), .LVL(LVL), .W_CTRL(W_CTRL), .SEL_MASK(SEL_MASK), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .din(din_if), .dout(dout_if), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   logic [W_OUT-1:0] exp_q[$];
   logic [W_OUT-1:0] got_q[$];
   logic [W_OUT-1:0] held;
   bit               held_v = 0;
   int               model_drops = 0;
   bit               prev_valid = 0;
   bit               prev_ready = 0;
   logic [W_OUT-1:0] prev_data;
   bit               rand_done;

   // Codes 1 and 3 are the kept ones.
   function automatic bit isKept(input logic [1:0] c);
      return (c == 2'd1) || (c == 2'd3);
   endfunction

   function automatic logic [W_OUT-1:0] gotAt(input int i);
      if (got_q.size() > i) return got_q[i];
      return '1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Transaction-level model: the last kept item of a transaction is held
   // until its transaction closes or another kept item arrives.
   task automatic modelAccept(input logic [1:0] c, input logic [15:0] d, input logic [1:0] e);
      if (isKept(c)) begin
         if (held_v) exp_q.push_back(held);
         if (e[0]) begin
            exp_q.push_back({e, d});
            held_v = 0;
         end else begin
            held   = {e, d};
            held_v = 1;
         end
      end else if (e[0]) begin
         if (held_v) begin
            held[W_OUT-1 -: LVL] = e;
            exp_q.push_back(held);
            held_v = 0;
         end else if (model_drops < 65535) begin
            model_drops++;
         end
      end
   endtask

   // Compare process, sampled on the falling edge while inputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("drop_cnt", 32'(drop_cnt), 32'(model_drops));
         if (prev_valid && !prev_ready) begin
            checkOutput("hold_valid", 32'(dout_if.valid), 32'd1);
            checkOutput("hold_data", 32'(dout_if.data), 32'(prev_data));
         end
         if (dout_if.valid) begin
            checkOutput("expected_pending", 32'(exp_q.size() != 0), 32'd1);
            if (dout_if.ready && exp_q.size() != 0) begin
               checkOutput("stream_data", 32'(dout_if.data), 32'(exp_q.pop_front()));
               got_q.push_back(dout_if.data);
            end
         end
         if (din_if.valid && !isKept(din_if.data[W_DIN +: W_CTRL]))
            checkOutput("drop_ready", 32'(din_if.ready), 32'd1);
         if (din_if.valid && din_if.ready)
            modelAccept(din_if.data[W_DIN +: W_CTRL], din_if.data[W_DIN-1:0],
                        din_if.data[W_DIN+W_CTRL +: LVL]);
         prev_valid = dout_if.valid;
         prev_ready = dout_if.ready;
         prev_data  = dout_if.data;
      end else begin
         prev_valid = 0;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] c, input logic [15:0] d, input logic [1:0] e);
      bit hs;
      hs = 0;
      din_if.valid = 1'b1;
      din_if.data  = {e, c, d};
      for (int i = 0; i < 200 && !hs; i++) begin
         @(negedge clk);
         hs = din_if.ready;
         @(posedge clk);
         #1;
      end
      din_if.valid = 1'b0;
      if (!hs) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake_timeout: actual=stalled required=accepted data=%0h", d);
      end
   endtask

   task automatic drain();
      bit done;
      done = 0;
      dout_if.ready = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         idle(1);
         done = (exp_q.size() == 0) && !dout_if.valid;
      end
      checkOutput("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      din_if.valid  = 1'b0;
      din_if.data   = '0;
      dout_if.ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("reset_dout_valid", 32'(dout_if.valid), 32'd0);
      checkOutput("reset_drop_cnt", 32'(drop_cnt), 32'd0);
      idle(1);

      $display("[TB] case 1: basic filter and eot merge");
      got_q.delete();
      applyStimulus(2'd1, 16'd1, 2'b00);
      applyStimulus(2'd0, 16'd2, 2'b00);
      applyStimulus(2'd1, 16'd3, 2'b00);
      applyStimulus(2'd0, 16'd4, 2'b01);
      drain();
      checkOutput("c1_count", 32'(got_q.size()), 32'd2);
      checkOutput("c1_item0", 32'(gotAt(0)), 32'h0_0001);
      checkOutput("c1_item1", 32'(gotAt(1)), 32'h1_0003);
      checkOutput("c1_drop_cnt", 32'(drop_cnt), 32'd0);

      $display("[TB] case 2: empty transaction and latency");
      got_q.delete();
      applyStimulus(2'd0, 16'd5, 2'b00);
      applyStimulus(2'd0, 16'd6, 2'b01);
      idle(2);
      checkOutput("c2_drop_cnt", 32'(drop_cnt), 32'd1);
      checkOutput("c2_no_output", 32'(got_q.size()), 32'd0);
      applyStimulus(2'd1, 16'd7, 2'b01);
      @(negedge clk);
      checkOutput("c2_valid_n1", 32'(dout_if.valid), 32'd0);
      @(negedge clk);
      checkOutput("c2_valid_n2", 32'(dout_if.valid), 32'd1);
      checkOutput("c2_data_n2", 32'(dout_if.data), 32'h1_0007);
      idle(1);
      drain();

      $display("[TB] case 3: two-bit ctrl and two eot levels");
      got_q.delete();
      applyStimulus(2'd1, 16'd10, 2'b00);
      applyStimulus(2'd3, 16'd11, 2'b00);
      applyStimulus(2'd0, 16'd12, 2'b00);
      applyStimulus(2'd2, 16'd13, 2'b11);
      drain();
      checkOutput("c3_count", 32'(got_q.size()), 32'd2);
      checkOutput("c3_item0", 32'(gotAt(0)), 32'h0_000A);
      checkOutput("c3_item1", 32'(gotAt(1)), 32'h3_000B);
      checkOutput("c3_drop_cnt", 32'(drop_cnt), 32'd1);

      $display("[TB] case 4/5: backpressure and push with pop on full");
      got_q.delete();
      dout_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(2'd1, 16'(20 + i), 2'b00);
      din_if.valid = 1'b1;
      din_if.data  = {2'b00, 2'd1, 16'd24};
      @(negedge clk);
      checkOutput("c4_sel_stalled", 32'(din_if.ready), 32'd0);
      checkOutput("c4_full_valid", 32'(dout_if.valid), 32'd1);
      checkOutput("c4_head", 32'(dout_if.data), 32'h0_0014);
      @(posedge clk);
      #1 din_if.valid = 1'b0;
      applyStimulus(2'd0, 16'd99, 2'b00);
      dout_if.ready = 1'b1;
      din_if.valid  = 1'b1;
      din_if.data   = {2'b00, 2'd1, 16'd24};
      @(negedge clk);
      checkOutput("c5_push_pop_full", 32'(din_if.ready), 32'd1);
      @(posedge clk);
      #1 din_if.valid = 1'b0;
      applyStimulus(2'd1, 16'd25, 2'b00);
      applyStimulus(2'd0, 16'd26, 2'b01);
      drain();
      checkOutput("c4_count", 32'(got_q.size()), 32'd6);
      for (int i = 0; i < 5; i++) checkOutput("c4_order", 32'(gotAt(i)), 32'(20 + i));
      checkOutput("c4_last", 32'(gotAt(5)), 32'h1_0019);

      $display("[TB] case 6: reset with occupied buffers");
      dout_if.ready = 1'b0;
      applyStimulus(2'd1, 16'd40, 2'b00);
      applyStimulus(2'd1, 16'd41, 2'b00);
      applyStimulus(2'd1, 16'd42, 2'b00);
      rst = 1'b0;
      #1;
      checkOutput("c6_valid_async", 32'(dout_if.valid), 32'd0);
      checkOutput("c6_drop_cnt", 32'(drop_cnt), 32'd0);
      exp_q.delete();
      got_q.delete();
      held_v      = 0;
      model_drops = 0;
      @(posedge clk);
      #1 rst = 1'b1;
      dout_if.ready = 1'b1;
      applyStimulus(2'd1, 16'd1, 2'b00);
      applyStimulus(2'd0, 16'd2, 2'b00);
      applyStimulus(2'd1, 16'd3, 2'b00);
      applyStimulus(2'd0, 16'd4, 2'b01);
      drain();
      checkOutput("c6_count", 32'(got_q.size()), 32'd2);
      checkOutput("c6_item0", 32'(gotAt(0)), 32'h0_0001);
      checkOutput("c6_item1", 32'(gotAt(1)), 32'h1_0003);

      $display("[TB] random traffic with random backpressure");
      rand_done = 0;
      fork
         begin
            for (int n = 0; n < 1500; n++) begin
               logic [1:0] c, e;
               c = 2'($urandom_range(0, 3));
               e = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
               if ($urandom_range(0, 3) == 0) idle(1);
               applyStimulus(c, 16'($urandom), e);
            end
            applyStimulus(2'd0, 16'd0, 2'b01);
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               dout_if.ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      drain();
      checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
